// File: rtl/dmem_ahb_responder.sv
// AHB-lite data-memory responder: word RAM with stored 7-bit SECDED checksums, zero-wait-state
// reads/writes and a two-cycle ERROR response. Define RESP_PARITY_CHECK_EN to enable address/control parity checking.
module dmem_ahb_responder #(
  parameter int          AW   = 10,
  parameter logic [31:0] BASE = 32'h0
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_hsel_i,
  input  logic [31:0] s_haddr_i,
  input  logic [2:0]  s_hsize_i,
  input  logic [1:0]  s_htrans_i,
  input  logic        s_hwrite_i,
  input  logic [5:0]  s_hparity_i,
  input  logic        s_hready_i,
  input  logic [31:0] s_hwdata_i,
  input  logic [6:0]  s_hwdcheck_i,
  output logic [31:0] s_hrdata_o,
  output logic [6:0]  s_hrdcheck_o,
  output logic        s_hreadyout_o,
  output logic        s_hresp_o
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ERR1,
    ERR2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          write_q;
  logic          valid_q;
  logic          hreadyout_q;
  logic          hresp_q;

  logic [31:0]   mem [DEPTH];
  logic [6:0]    chk [DEPTH];

  logic          accept;
  logic          range_err;
  logic          align_err;
  logic          size_err;
  logic          parity_err;
  logic          xfer_err;
  logic [3:0]    lane_en;
  logic          write_en;
  logic          rd_active;

  assign accept    = s_hsel_i & s_htrans_i[1] & s_hready_i;
  assign range_err = (s_haddr_i[31:AW+2] != BASE[31:AW+2]);
  assign size_err  = (s_hsize_i > 3'd2);

  always_comb begin
    align_err = 1'b0;
    case (s_hsize_i)
      3'd1:    align_err = s_haddr_i[0];
      3'd2:    align_err = |s_haddr_i[1:0];
      default: align_err = 1'b0;
    endcase
  end

`ifdef RESP_PARITY_CHECK_EN
  logic [5:0] parity_calc;

  assign parity_calc = {^s_htrans_i,
                        (^s_hsize_i) ^ s_hwrite_i,
                        ^s_haddr_i[31:24],
                        ^s_haddr_i[23:16],
                        ^s_haddr_i[15:8],
                        ^s_haddr_i[7:0]};
  assign parity_err  = (parity_calc != s_hparity_i);
`else
  logic unused_parity;

  assign unused_parity = ^{s_hparity_i, s_htrans_i[0]};
  assign parity_err    = 1'b0;
`endif

  assign xfer_err = range_err | align_err | size_err | parity_err;

  // ERR1 always advances to ERR2, so any address phase offered during it is dropped.
  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      case (state_q)
        ERR1: begin
          state_q     <= ERR2;
          valid_q     <= 1'b0;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          if (accept) begin
            idx_q   <= s_haddr_i[AW+1:2];
            off_q   <= s_haddr_i[1:0];
            size_q  <= s_hsize_i[1:0];
            write_q <= s_hwrite_i;
            if (xfer_err) begin
              state_q     <= ERR1;
              valid_q     <= 1'b0;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else begin
              state_q     <= DATA;
              valid_q     <= 1'b1;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end else begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      2'd0:    lane_en = 4'b0001 << off_q;
      2'd1:    lane_en = 4'b0011 << off_q;
      default: lane_en = 4'b1111;
    endcase
  end

  // Gating on reset keeps a write whose data phase is cut short by reset out of the array.
  assign write_en = s_resetn_i & valid_q & write_q;

  always_ff @(posedge s_clk_i) begin
    if (write_en) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) begin
          mem[idx_q][8*b +: 8] <= s_hwdata_i[8*b +: 8];
        end
      end
      chk[idx_q] <= s_hwdcheck_i;
    end
  end

  assign rd_active     = valid_q & ~write_q;
  assign s_hrdata_o    = rd_active ? mem[idx_q] : 32'h0;
  assign s_hrdcheck_o  = rd_active ? chk[idx_q] : 7'h0;
  assign s_hreadyout_o = hreadyout_q;
  assign s_hresp_o     = hresp_q;

endmodule

// File: tb/tb_dmem_ahb_responder.sv
// Directed table-driven bench for dmem_ahb_responder; hand sequences cover reset mid-transfer.
module tb_dmem_ahb_responder;

  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_4000;

  logic        s_clk_i;
  logic        s_resetn_i;
  logic        s_hsel_i;
  logic [31:0] s_haddr_i;
  logic [2:0]  s_hsize_i;
  logic [1:0]  s_htrans_i;
  logic        s_hwrite_i;
  logic [5:0]  s_hparity_i;
  logic        s_hready_i;
  logic [31:0] s_hwdata_i;
  logic [6:0]  s_hwdcheck_i;
  logic [31:0] s_hrdata_o;
  logic [6:0]  s_hrdcheck_o;
  logic        s_hreadyout_o;
  logic        s_hresp_o;

  int compared;
  int mismatched;

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
    logic [6:0]  wchk;
    logic        flip;
    logic [31:0] eData;
    logic [6:0]  eChk;
    logic        eRdy;
    logic        eResp;
  } vec_t;

  vec_t vecs[64];
  int   numRows;

  dmem_ahb_responder #(.AW(AW), .BASE(BASE)) dut (
    .s_clk_i       (s_clk_i),
    .s_resetn_i    (s_resetn_i),
    .s_hsel_i      (s_hsel_i),
    .s_haddr_i     (s_haddr_i),
    .s_hsize_i     (s_hsize_i),
    .s_htrans_i    (s_htrans_i),
    .s_hwrite_i    (s_hwrite_i),
    .s_hparity_i   (s_hparity_i),
    .s_hready_i    (s_hready_i),
    .s_hwdata_i    (s_hwdata_i),
    .s_hwdcheck_i  (s_hwdcheck_i),
    .s_hrdata_o    (s_hrdata_o),
    .s_hrdcheck_o  (s_hrdcheck_o),
    .s_hreadyout_o (s_hreadyout_o),
    .s_hresp_o     (s_hresp_o)
  );

  // Single-slave bus: the interconnect's HREADY is the slave's own HREADYOUT.
  assign s_hready_i = s_hreadyout_o;

  initial s_clk_i = 1'b0;
  always #5 s_clk_i = ~s_clk_i;

  function automatic logic [5:0] calcParity(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] tr, input logic wr);
    return {^tr, (^sz) ^ wr, ^a[31:24], ^a[23:16], ^a[15:8], ^a[7:0]};
  endfunction

  task automatic addRow(input logic sel, input logic [31:0] addr, input logic [2:0] size,
                        input logic wr, input logic [31:0] wdata, input logic [6:0] wchk,
                        input logic flip, input logic [31:0] eData, input logic [6:0] eChk,
                        input logic eRdy, input logic eResp);
    vecs[numRows].sel   = sel;
    vecs[numRows].addr  = addr;
    vecs[numRows].size  = size;
    vecs[numRows].wr    = wr;
    vecs[numRows].wdata = wdata;
    vecs[numRows].wchk  = wchk;
    vecs[numRows].flip  = flip;
    vecs[numRows].eData = eData;
    vecs[numRows].eChk  = eChk;
    vecs[numRows].eRdy  = eRdy;
    vecs[numRows].eResp = eResp;
    numRows++;
  endtask

  task automatic driveBus(input logic sel, input logic [31:0] addr, input logic [2:0] size,
                          input logic wr, input logic [31:0] wdata, input logic [6:0] wchk,
                          input logic flip);
    logic [1:0] tr;
    tr           = sel ? 2'b10 : 2'b00;
    s_hsel_i     = sel;
    s_haddr_i    = addr;
    s_hsize_i    = size;
    s_htrans_i   = tr;
    s_hwrite_i   = wr;
    s_hparity_i  = calcParity(addr, size, tr, wr) ^ {flip, 5'b0};
    s_hwdata_i   = wdata;
    s_hwdcheck_i = wchk;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveBus(v.sel, v.addr, v.size, v.wr, v.wdata, v.wchk, v.flip);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] eData, input logic [6:0] eChk,
                             input logic eRdy, input logic eResp);
    compared++;
    if (s_hrdata_o !== eData) begin
      mismatched++;
      $display("[TB] FAIL %s hrdata got %h expected %h", tag, s_hrdata_o, eData);
    end
    compared++;
    if (s_hrdcheck_o !== eChk) begin
      mismatched++;
      $display("[TB] FAIL %s hrdcheck got %h expected %h", tag, s_hrdcheck_o, eChk);
    end
    compared++;
    if (s_hreadyout_o !== eRdy) begin
      mismatched++;
      $display("[TB] FAIL %s hreadyout got %b expected %b", tag, s_hreadyout_o, eRdy);
    end
    compared++;
    if (s_hresp_o !== eResp) begin
      mismatched++;
      $display("[TB] FAIL %s hresp got %b expected %b", tag, s_hresp_o, eResp);
    end
  endtask

  task automatic nextCycle();
    @(posedge s_clk_i);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    numRows    = 0;

    // Word write then read
    addRow(1, BASE + 32'h10, 3'd2, 1, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 0);
    addRow(1, BASE + 32'h10, 3'd2, 0, 32'hDEADBEEF, 7'h5A, 0, 32'h0, 7'h0, 1, 0);
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'hDEADBEEF, 7'h5A, 1, 0);
    // Byte lane write at offset 2
    addRow(1, BASE + 32'h4, 3'd2, 1, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 0);
    addRow(1, BASE + 32'h6, 3'd0, 1, 32'h11223344, 7'h22, 0, 32'h0, 7'h0, 1, 0);
    addRow(1, BASE + 32'h4, 3'd2, 0, 32'h00AB0000, 7'h13, 0, 32'h0, 7'h0, 1, 0);
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'h11AB3344, 7'h13, 1, 0);
    // Out of range read; address offered during ERR1 must be dropped
    addRow(1, BASE + (32'd4 << AW), 3'd2, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 0);
    addRow(1, BASE + 32'h10, 3'd2, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 0, 1);
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 1);
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 0);
    // Misaligned half write must not touch memory
    addRow(1, BASE + 32'h8, 3'd2, 1, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 0);
    addRow(1, BASE + 32'h9, 3'd1, 1, 32'hCAFEF00D, 7'h33, 0, 32'h0, 7'h0, 1, 0);
    addRow(0, 32'h0, 3'd0, 0, 32'hFFFFFFFF, 7'h7F, 0, 32'h0, 7'h0, 0, 1);
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 1);
    addRow(1, BASE + 32'h8, 3'd2, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 0);
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'hCAFEF00D, 7'h33, 1, 0);
    // Aligned upper half write, then byte-sized read returns the full word
    addRow(1, BASE + 32'hA, 3'd1, 1, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 0);
    addRow(1, BASE + 32'hB, 3'd0, 0, 32'hBEEF0000, 7'h44, 0, 32'h0, 7'h0, 1, 0);
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'hBEEFF00D, 7'h44, 1, 0);
    // Oversized transfer
    addRow(1, BASE + 32'h10, 3'd3, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 0);
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 0, 1);
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 1);
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 0);
    // Flipped htrans parity bit on a valid read
    addRow(1, BASE + 32'h10, 3'd2, 0, 32'h0, 7'h0, 1, 32'h0, 7'h0, 1, 0);
`ifdef RESP_PARITY_CHECK_EN
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 0, 1);
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 1);
`else
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'hDEADBEEF, 7'h5A, 1, 0);
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 0);
`endif
    addRow(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0, 32'h0, 7'h0, 1, 0);

    s_resetn_i = 1'b0;
    driveBus(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0);
    repeat (2) nextCycle();
    @(negedge s_clk_i);
    checkOutput("reset_state", 32'h0, 7'h0, 1, 0);
    nextCycle();
    s_resetn_i = 1'b1;
    nextCycle();

    for (int i = 0; i < numRows; i++) begin
      applyStimulus(vecs[i]);
      @(negedge s_clk_i);
      checkOutput($sformatf("row%0d", i), vecs[i].eData, vecs[i].eChk, vecs[i].eRdy, vecs[i].eResp);
      nextCycle();
    end

    // Reset during a write data phase must abandon the write
    driveBus(1, BASE + 32'h0, 3'd2, 1, 32'h0, 7'h0, 0);
    nextCycle();
    driveBus(0, 32'h0, 3'd0, 0, 32'h12345678, 7'h21, 0);
    nextCycle();
    driveBus(1, BASE + 32'h0, 3'd2, 1, 32'h0, 7'h0, 0);
    nextCycle();
    driveBus(0, 32'h0, 3'd0, 0, 32'hFFFFFFFF, 7'h7F, 0);
    s_resetn_i = 1'b0;
    nextCycle();
    @(negedge s_clk_i);
    checkOutput("reset_hold", 32'h0, 7'h0, 1, 0);
    nextCycle();
    s_resetn_i = 1'b1;
    driveBus(1, BASE + 32'h0, 3'd2, 0, 32'h0, 7'h0, 0);
    nextCycle();
    driveBus(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0);
    @(negedge s_clk_i);
    checkOutput("reset_read", 32'h12345678, 7'h21, 1, 0);
    nextCycle();

    // Reset during ERR1 must clear the error response
    driveBus(1, BASE + (32'd4 << AW), 3'd2, 0, 32'h0, 7'h0, 0);
    nextCycle();
    driveBus(0, 32'h0, 3'd0, 0, 32'h0, 7'h0, 0);
    s_resetn_i = 1'b0;
    @(negedge s_clk_i);
    checkOutput("err1_pre_reset", 32'h0, 7'h0, 0, 1);
    nextCycle();
    @(negedge s_clk_i);
    checkOutput("err_reset", 32'h0, 7'h0, 1, 0);
    nextCycle();
    s_resetn_i = 1'b1;
    nextCycle();
    @(negedge s_clk_i);
    checkOutput("post_err_reset", 32'h0, 7'h0, 1, 0);
    nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_ahb_responder.md
# dmem_ahb_responder

AHB-lite data-memory responder serving the core's load/store bus, the target end of the LSU's data interface. It holds a word-organised RAM where every 32-bit word carries a stored 7-bit SECDED checksum. Reads return the stored word plus its checksum for checking in the core; writes store byte lanes together with the master-supplied checksum. Bad transfers get a two-cycle AHB ERROR response: address out of range, misaligned, or, when enabled, failing the address/control parity check.

## Interface
- AW, 10, word-address bits; memory depth = 2^AW words
- BASE, 32'h0, base byte address; must be aligned to 2^(AW+2)

- s_clk_i  in  1  clock
- s_resetn_i  in  1  reset, synchronous, active-low
- s_hsel_i  in  1  slave select
- s_haddr_i  in  32  transfer address
- s_hsize_i  in  3  transfer size (0 byte, 1 half, 2 word)
- s_htrans_i  in  2  transfer type; bit 1 marks a valid transfer
- s_hwrite_i  in  1  write indicator
- s_hparity_i  in  6  address/control parity
- s_hready_i  in  1  bus-level ready (end of previous data phase)
- s_hwdata_i  in  32  write data, data phase
- s_hwdcheck_i  in  7  write-data checksum, data phase
- s_hrdata_o  out  32  read data
- s_hrdcheck_o  out  7  read-data checksum
- s_hreadyout_o  out  1  transfer done
- s_hresp_o  out  1  error response

## Operation
- Address phase is accepted when s_hsel_i & s_htrans_i[1] & s_hready_i. On acceptance the block registers the following: word index haddr[AW+1:2], byte offset haddr[1:0], hsize[1:0], hwrite, valid, and the error flag.
- The error flag is set by any of these:
  - haddr[31:AW+2] != BASE[31:AW+2]
  - misalignment: half with haddr[0]=1, or word with haddr[1:0]!=0
  - hsize > 2
  - parity fail, only when the parity check is enabled (see Configuration)
- FSM states:
  - IDLE
  - DATA: a valid transfer with no error is in its data phase.
  - ERR1
  - ERR2
- FSM transitions:
  - Accepted transfer with error: go to ERR1.
  - Accepted transfer without error: go to DATA.
  - No accepted transfer: go to IDLE.
  - ERR1 -> ERR2 unconditionally.
  - From DATA or ERR2, a new accepted transfer follows the rules above.
  - Address phases arriving during ERR1 are ignored, because s_hready_i is low.
- Read data phase:
  - s_hrdata_o = mem[idx] and s_hrdcheck_o = chk[idx], combinational from the registered index.
  - The full word is always returned, whatever the size.
- Write data phase, committed at the clock edge that ends DATA:
  - Byte lanes are enabled by size and offset: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
  - Only enabled lanes of mem[idx] are updated.
  - chk[idx] <= s_hwdcheck_i on every write. The master has already merged the word and supplies the full-word checksum.
- Outputs outside a read data phase:
  - s_hrdata_o = 0 and s_hrdcheck_o = 0.
- Error transfers never modify memory.
- The memory array is not reset. Reset affects only control state.

## Timing
- Reset values:
  - FSM IDLE, registered valid = 0
  - s_hreadyout_o = 1, s_hresp_o = 0, s_hrdata_o = 0, s_hrdcheck_o = 0
- Reset asserted mid-transfer aborts it. A pending write is not committed.
- Zero wait states: s_hreadyout_o = 1 in IDLE, DATA and ERR2.
- ERROR response:
  - ERR1: s_hreadyout_o = 0, s_hresp_o = 1.
  - ERR2: s_hreadyout_o = 1, s_hresp_o = 1.
- Read latency: data is valid in the cycle after address acceptance.
- Back-to-back write then read of the same word: the write commits at the end of its data phase. The following read data phase returns the new data and checksum.
- Simultaneous address phase and write data phase are allowed. The address is registered and the write is committed on the same edge.

## Configuration
- Macro RESP_PARITY_CHECK_EN, when defined, checks s_hparity_i against these computed values:
  - [3:0]: per-byte XOR of haddr (bit 0 = ^haddr[7:0])
  - [4]: ^hsize ^ hwrite
  - [5]: ^htrans
- Any mismatch on an accepted address phase sets the error flag.
- When the macro is undefined, s_hparity_i is ignored and only range, alignment and size errors apply.

## Test plan
- Word write then read:
  - Write 0xDEADBEEF, chk 0x5A to BASE+0x10, then read BASE+0x10.
  - Required: hrdata 0xDEADBEEF, hrdcheck 0x5A, hreadyout stays 1 on both transfers.
- Byte lane write:
  - Word 0x11223344 at BASE+0x4.
  - Byte write to BASE+0x6 with hwdata 0x00AB0000, chk 0x13.
  - Required: readback 0x11AB3344 and hrdcheck 0x13.
- Out of range:
  - Read BASE+(4<<AW).
  - Required: cycle 1 hreadyout=0, hresp=1; cycle 2 hreadyout=1, hresp=1.
  - An address phase presented during cycle 1 is ignored.
- Misaligned half write:
  - Half write to BASE+0x9 after BASE+0x8 holds 0xCAFEF00D.
  - Required: ERROR response, and readback is still 0xCAFEF00D.
- Parity (RESP_PARITY_CHECK_EN defined):
  - Flip s_hparity_i[5] on a valid read.
  - Required: ERROR response.
  - With the macro undefined, the same stimulus returns data normally.
- Reset mid-write:
  - Assert s_resetn_i during a write data phase to BASE+0x0, which holds 0x12345678.
  - Required: next read returns 0x12345678; hreadyout=1 and hresp=0 during reset.
